// File: rtl/instr_register_pkg.sv
`default_nettype none
// ============================================================================
// Package     : instr_register_pkg
// Description : Shared types for the instruction register and its write/read
//               scheduler: opcode, operand, address and instruction word
//               types, the scheduler state encoding and the register depth.
// Revision    : 1.0 - initial release
// ============================================================================
package instr_register_pkg;

  localparam int NUM_ENTRIES = 32;

  typedef enum logic [3:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7
  } opcode_t;

  typedef logic signed [31:0] operand_t;
  typedef logic [4:0]         address_t;

  typedef struct packed {
    opcode_t            opc;
    operand_t           op_a;
    operand_t           op_b;
    logic signed [63:0] result;
  } instruction_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/instr_reg_scheduler_arb.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter_2
// Description : Two-port round-robin arbiter. A lone requester is granted;
//               when both request, the port not granted last wins. The
//               last_grant register starts at 1 so port 0 wins first.
// Ports       : clk, reset   - clock, synchronous active-high reset
//               req[1:0]     - per-port request
//               enable       - grants allowed this cycle
//               grant[1:0]   - one-hot (or zero) grant, combinational
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter_2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       enable,
  output logic [1:0] grant
);

  logic last_grant;

  always_comb begin
    grant = 2'b00;
    if (enable) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_grant ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  // A grant is only issued to a requesting port, so any grant is a transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (grant != 2'b00) begin
      last_grant <= grant[1];
    end
  end

endmodule
`default_nettype wire

// File: rtl/instr_reg_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : instr_reg_scheduler
// Description : Schedules writes from two requesters into an external
//               instruction register and sweeps its contents back out.
// Ports       : clk, reset                 - clock, sync active-high reset
//               req_valid/req_ready        - per-requester handshake
//               req{0,1}_opcode/operand_*  - requester write data
//               load_en, write_pointer,
//               opcode, operand_a/b        - registered write port
//               read_pointer,
//               instruction_word           - read port (comb. read data)
//               rd_start, clear            - sweep start, bookkeeping clear
//               rd_valid, rd_instr, rd_done- read-back stream
//               count, full                - occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module instr_reg_scheduler
  import instr_register_pkg::*;
#(
  parameter int NUM_ENTRIES = instr_register_pkg::NUM_ENTRIES
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  opcode_t      req0_opcode,
  input  operand_t     req0_operand_a,
  input  operand_t     req0_operand_b,
  input  opcode_t      req1_opcode,
  input  operand_t     req1_operand_a,
  input  operand_t     req1_operand_b,
  output logic         load_en,
  output address_t     write_pointer,
  output opcode_t      opcode,
  output operand_t     operand_a,
  output operand_t     operand_b,
  output address_t     read_pointer,
  input  instruction_t instruction_word,
  input  logic         rd_start,
  input  logic         clear,
  output logic         rd_valid,
  output instruction_t rd_instr,
  output logic         rd_done,
  output logic [5:0]   count,
  output logic         full
);

  sched_state_t state;
  address_t     wr_ptr;
  address_t     rd_ptr;
  logic         accept;
  logic         transfer;

  assign full         = (count == 6'(NUM_ENTRIES));
  assign accept       = (state == IDLE) && !full && !clear;
  assign transfer     = (req_ready != 2'b00);
  assign read_pointer = rd_ptr;

  rr_arbiter_2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    (req_valid),
    .enable (accept),
    .grant  (req_ready)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      count         <= 6'd0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      load_en       <= 1'b0;
      write_pointer <= '0;
      opcode        <= ZERO;
      operand_a     <= '0;
      operand_b     <= '0;
      rd_valid      <= 1'b0;
      rd_instr      <= '0;
      rd_done       <= 1'b0;
    end else begin
      // Write path: register the granted port's data one cycle after transfer.
      load_en <= transfer;
      if (transfer) begin
        write_pointer <= wr_ptr;
        wr_ptr        <= wr_ptr + 5'd1;
        count         <= count + 6'd1;
        if (req_ready[1]) begin
          opcode    <= req1_opcode;
          operand_a <= req1_operand_a;
          operand_b <= req1_operand_b;
        end else begin
          opcode    <= req0_opcode;
          operand_a <= req0_operand_a;
          operand_b <= req0_operand_b;
        end
      end else if (clear && state == IDLE) begin
        count  <= 6'd0;
        wr_ptr <= '0;
      end

      // Read sweep.
      rd_valid <= 1'b0;
      rd_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (rd_start) begin
            rd_ptr <= '0;
            // A concurrent clear empties the register, so the sweep is empty.
            if (count != 6'd0 && !clear) begin
              state <= READ;
            end else begin
              state   <= DONE;
              rd_done <= 1'b1;
            end
          end
        end
        READ: begin
          rd_valid <= 1'b1;
          rd_instr <= instruction_word;
          rd_ptr   <= rd_ptr + 5'd1;
          // rd_done rises together with the last entry's rd_valid.
          if ({1'b0, rd_ptr} == count - 6'd1) begin
            state   <= DONE;
            rd_done <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_reg_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_reg_scheduler
// Description : Directed self-checking bench for instr_reg_scheduler. Holds a
//               behavioural instruction register that executes each written
//               instruction and serves combinational read data.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_reg_scheduler;
  import instr_register_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  opcode_t      req0_opcode, req1_opcode;
  operand_t     req0_operand_a, req0_operand_b, req1_operand_a, req1_operand_b;
  logic         load_en;
  address_t     write_pointer;
  opcode_t      opcode;
  operand_t     operand_a, operand_b;
  address_t     read_pointer;
  instruction_t instruction_word;
  logic         rd_start, clear;
  logic         rd_valid;
  instruction_t rd_instr;
  logic         rd_done;
  logic [5:0]   count;
  logic         full;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  instr_reg_scheduler #(.NUM_ENTRIES(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_opcode(req0_opcode), .req0_operand_a(req0_operand_a), .req0_operand_b(req0_operand_b),
    .req1_opcode(req1_opcode), .req1_operand_a(req1_operand_a), .req1_operand_b(req1_operand_b),
    .load_en(load_en), .write_pointer(write_pointer),
    .opcode(opcode), .operand_a(operand_a), .operand_b(operand_b),
    .read_pointer(read_pointer), .instruction_word(instruction_word),
    .rd_start(rd_start), .clear(clear),
    .rd_valid(rd_valid), .rd_instr(rd_instr), .rd_done(rd_done),
    .count(count), .full(full)
  );

  // Behavioural instruction register.
  instruction_t mem [32];

  function automatic logic signed [63:0] exec(opcode_t o, operand_t a, operand_t b);
    logic signed [63:0] la, lb;
    la = 64'(a);
    lb = 64'(b);
    case (o)
      PASSA:   return la;
      PASSB:   return lb;
      ADD:     return la + lb;
      SUB:     return la - lb;
      MULT:    return la * lb;
      DIV:     return (lb == 0) ? 64'sd0 : la / lb;
      MOD:     return (lb == 0) ? 64'sd0 : la % lb;
      default: return 64'sd0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (load_en) begin
      mem[write_pointer] <= '{opc: opcode, op_a: operand_a, op_b: operand_b,
                              result: exec(opcode, operand_a, operand_b)};
    end
  end

  assign instruction_word = mem[read_pointer];

  function automatic instruction_t mk(opcode_t o, int a, int b, longint r);
    instruction_t t;
    t.opc    = o;
    t.op_a   = a;
    t.op_b   = b;
    t.result = r;
    return t;
  endfunction

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic write0(opcode_t o, int a, int b);
    req_valid      = 2'b01;
    req0_opcode    = o;
    req0_operand_a = a;
    req0_operand_b = b;
    tick();
    req_valid = 2'b00;
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 2'b00;
    req0_opcode = ZERO; req0_operand_a = 0; req0_operand_b = 0;
    req1_opcode = ZERO; req1_operand_a = 0; req1_operand_b = 0;
    rd_start = 1'b0;
    clear    = 1'b0;
    do_reset();

    // Reset state.
    check("rst_load_en",  load_en, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_done",  rd_done, 0);
    check("rst_count",    count, 0);
    check("rst_full",     full, 0);
    check("rst_wp",       write_pointer, 0);
    check("rst_rp",       read_pointer, 0);
    check("rst_opcode",   opcode, ZERO);
    check("rst_rd_instr", rd_instr, 0);

    // Single write from port 0.
    req_valid = 2'b01; req0_opcode = ADD; req0_operand_a = 5; req0_operand_b = 3;
    #1 check("w1_ready", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    check("w1_load_en", load_en, 1);
    check("w1_wp",      write_pointer, 0);
    check("w1_opcode",  opcode, ADD);
    check("w1_opa",     operand_a, 5);
    check("w1_opb",     operand_b, 3);
    check("w1_count",   count, 1);
    tick();
    check("w1_load_off", load_en, 0);

    // Both ports requesting: alternate 0,1,0,1.
    do_reset();
    req0_opcode = ADD; req0_operand_a = 1; req0_operand_b = 2;
    req1_opcode = SUB; req1_operand_a = 7; req1_operand_b = 4;
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1 check("rr_ready", req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
      tick();
      check("rr_load_en", load_en, 1);
      check("rr_wp",      write_pointer, k);
      check("rr_opcode",  opcode, (k % 2 == 0) ? ADD : SUB);
    end
    req_valid = 2'b00;
    check("rr_count", count, 4);

    // Three-entry sweep.
    do_reset();
    write0(ADD, 5, 3);
    write0(SUB, 9, 2);
    write0(MULT, 4, 6);
    tick();
    check("sw_count", count, 3);
    rd_start = 1'b1;
    tick();                                     // S+1: READ, rd_ptr 0
    rd_start = 1'b0;
    req_valid = 2'b01;
    #1 check("sw_ready_blocked", req_ready, 2'b00);
    check("sw_rp0",    read_pointer, 0);
    check("sw_valid0", rd_valid, 0);
    rd_start = 1'b1;                            // ignored outside IDLE
    tick();                                     // S+2
    rd_start = 1'b0;
    check("sw_valid1",  rd_valid, 1);
    check("sw_instr1",  rd_instr, mk(ADD, 5, 3, 8));
    check("sw_rp1",     read_pointer, 1);
    check("sw_no_load", load_en, 0);
    req_valid = 2'b00;
    tick();                                     // S+3
    check("sw_valid2", rd_valid, 1);
    check("sw_instr2", rd_instr, mk(SUB, 9, 2, 7));
    check("sw_done2",  rd_done, 0);
    tick();                                     // S+4: DONE
    check("sw_valid3", rd_valid, 1);
    check("sw_instr3", rd_instr, mk(MULT, 4, 6, 24));
    check("sw_done3",  rd_done, 1);
    tick();                                     // S+5: IDLE
    check("sw_valid_end", rd_valid, 0);
    check("sw_done_end",  rd_done, 0);
    tick();
    check("sw_no_restart", rd_valid, 0);
    check("sw_count_kept", count, 3);

    // Clear, then an empty sweep.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_count", count, 0);
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    check("empty_done",  rd_done, 1);
    check("empty_valid", rd_valid, 0);
    tick();
    check("empty_done_off", rd_done, 0);
    check("empty_valid_off", rd_valid, 0);

    // Fill to 32 entries from port 1, stall, then clear.
    req_valid = 2'b10;
    for (int i = 0; i < 32; i++) begin
      req1_opcode = PASSA; req1_operand_a = i; req1_operand_b = 0;
      tick();
      if (i == 31) check("fill_wp31", write_pointer, 31);
    end
    check("fill_count", count, 32);
    check("fill_full",  full, 1);
    #1 check("fill_ready", req_ready, 2'b00);
    tick();
    check("stall_load", load_en, 0);
    check("stall_count", count, 32);
    clear = 1'b1;
    #1 check("clr_ready", req_ready, 2'b00);
    tick();
    clear = 1'b0;
    check("refill_count", count, 0);
    check("refill_full",  full, 0);
    #1 check("refill_ready", req_ready, 2'b10);
    tick();
    req_valid = 2'b00;
    check("refill_load", load_en, 1);
    check("refill_wp",   write_pointer, 0);

    // Reset mid-sweep at rd_ptr = 1.
    do_reset();
    write0(ADD, 1, 1);
    write0(ADD, 2, 2);
    write0(ADD, 3, 3);
    tick();
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    tick();
    check("abort_rp", read_pointer, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_valid", rd_valid, 0);
    check("abort_done",  rd_done, 0);
    check("abort_count", count, 0);
    tick();
    check("abort_valid2", rd_valid, 0);
    check("abort_load",   load_en, 0);
    req_valid = 2'b01;
    #1 check("abort_idle_ready", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_reg_scheduler.md
INSTR_REG_SCHEDULER -- requirements
Module: instr_reg_scheduler

Interface
REQ-001 Parameter NUM_ENTRIES, default 32, number of instruction register entries; SHALL equal the register depth.
REQ-002 clk  input  1  single clock; all state SHALL update on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  2  per-requester write request; bit i = requester i.
REQ-005 req_ready  output  2  per-requester grant; a transfer occurs when req_valid[i] && req_ready[i].
REQ-006 req0_opcode, req1_opcode  input  opcode_t  requested opcode.
REQ-007 req0_operand_a, req0_operand_b, req1_operand_a, req1_operand_b  input  operand_t  requested operands.
REQ-008 load_en  output  1  write strobe to the instruction register.
REQ-009 write_pointer  output  address_t  write address to the instruction register.
REQ-010 opcode, operand_a, operand_b  output  opcode_t/operand_t  write data to the instruction register.
REQ-011 read_pointer  output  address_t  read address to the instruction register.
REQ-012 instruction_word  input  instruction_t  combinational read data from the instruction register.
REQ-013 rd_start  input  1  pulse that starts a read-back sweep.
REQ-014 clear  input  1  empties the scheduler's bookkeeping.
REQ-015 rd_valid  output  1  rd_instr valid this cycle.
REQ-016 rd_instr  output  instruction_t  registered read-back instruction.
REQ-017 rd_done  output  1  one-cycle end-of-sweep pulse.
REQ-018 count  output  6  number of entries written, range 0..32.
REQ-019 full  output  1  high when count == NUM_ENTRIES.

Function
REQ-020 req_ready SHALL be combinational: zero unless state == IDLE, !full and !clear.
REQ-021 Single request: the requesting port SHALL be granted.
REQ-022 Both requesting: grant the port not granted last; last_grant resets to 1, so port 0 wins first.
REQ-023 At most one req_ready bit SHALL be high per cycle.
REQ-024 Transfer in cycle N: in cycle N+1, load_en = 1, write_pointer = wr_ptr value at N, and opcode/operands = the granted port's data.
REQ-025 At the N->N+1 edge, wr_ptr SHALL increment and count SHALL increment.
REQ-026 load_en SHALL be low in every cycle not following a transfer.
REQ-027 wr_ptr SHALL be 5 bits and wrap 31->0; full blocks any write beyond 32 entries.
REQ-028 clear in IDLE SHALL zero count and wr_ptr next cycle; clear outside IDLE SHALL be ignored.
REQ-029 Read FSM states SHALL be IDLE, READ and DONE.
REQ-030 IDLE -> READ on rd_start with count > 0; rd_ptr loads 0.
REQ-031 IDLE -> DONE on rd_start with count == 0.
REQ-032 In READ: read_pointer = rd_ptr; next cycle rd_instr = instruction_word and rd_valid = 1; rd_ptr increments.
REQ-033 READ -> DONE when rd_ptr == count-1.
REQ-034 DONE: rd_done = 1 for exactly one cycle, then IDLE.
REQ-035 Sweep timing: N entries produce N consecutive rd_valid cycles; the last rd_valid coincides with rd_done.
REQ-036 rd_start outside IDLE SHALL be ignored.
REQ-037 A write issued in cycle N+1 (REQ-024) SHALL be readable by a sweep started at edge N+1 or later.
REQ-038 Writes SHALL NOT be granted during READ or DONE.
REQ-039 count SHALL be preserved across sweeps.

Reset
REQ-040 Reset SHALL force: state = IDLE, count = 0, wr_ptr = 0, rd_ptr = 0, last_grant = 1.
REQ-041 Reset SHALL force outputs: load_en = 0, rd_valid = 0, rd_done = 0, rd_instr = 0, write/read pointers = 0, opcode = ZERO, operands = 0.
REQ-042 Reset mid-sweep or mid-write SHALL abort with no further load_en or rd_valid.
REQ-043 The scheduler SHALL NOT clear instruction register contents.

Structure
REQ-044 instr_register_pkg SHALL hold opcode_t, operand_t, address_t, instruction_t, plus new sched_state_t {IDLE, READ, DONE} and NUM_ENTRIES.
REQ-045 Sub-module rr_arbiter_2 SHALL implement the 2-port round-robin grant and last_grant register.

Verification
REQ-046 Reset, then port 0 writes {ADD, 5, 3} -> next cycle load_en = 1, write_pointer = 0, opcode = ADD; count = 1.
REQ-047 Both ports valid for 4 cycles -> grants alternate 0,1,0,1; write_pointer 0..3; count = 4.
REQ-048 32 writes -> full = 1, req_ready = 0; 33rd request stalls; clear -> count = 0, ready returns.
REQ-049 3 entries written, rd_start -> read_pointer 0,1,2; rd_valid 3 cycles with matching entries (ADD 5+3 -> result 8); rd_done with 3rd.
REQ-050 rd_start with count = 0 -> rd_done pulse next cycle, no rd_valid.
REQ-051 reset asserted during READ at rd_ptr = 1 -> next cycle IDLE, rd_valid = 0, count = 0.
